// File: rtl/tick_pwm_gen.sv
// Tick-counted PWM generator with shadowed period/duty, wrap pulse and busy flag.
// Optional sticky wrap interrupt (irq/irq_clr) when TICK_PWM_IRQ_EN is defined.
module tick_pwm_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
`ifdef TICK_PWM_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic             pwm_out,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StStop = 2'd2} state_t;

  state_t           r_state;
  state_t           w_state_d;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_d;
  logic [WIDTH-1:0] r_period_s;
  logic [WIDTH-1:0] w_period_d;
  logic [WIDTH-1:0] r_duty_s;
  logic [WIDTH-1:0] w_duty_d;
  logic             r_wrap;
  logic             w_wrap_tick;

  assign w_wrap_tick = tick && (r_state != StIdle) && (r_cnt == r_period_s);

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_period_d = r_period_s;
    w_duty_d   = r_duty_s;
    case (r_state)
      StIdle: begin
        // Start cycle: any tick arriving now is deliberately ignored.
        if (en) begin
          w_state_d  = StRun;
          w_cnt_d    = '0;
          w_period_d = period;
          w_duty_d   = duty;
        end
      end
      StRun, StStop: begin
        if (w_wrap_tick) begin
          w_cnt_d = '0;
          if (en) begin
            w_state_d  = StRun;
            w_period_d = period;
            w_duty_d   = duty;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          if (tick) w_cnt_d = r_cnt + WIDTH'(1);
          w_state_d = en ? StRun : StStop;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_period_s <= '0;
      r_duty_s   <= '0;
      r_wrap     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_period_s <= w_period_d;
      r_duty_s   <= w_duty_d;
      r_wrap     <= w_wrap_tick;
    end
  end

`ifdef TICK_PWM_IRQ_EN
  logic r_irq;

  // Set has priority over clear so a wrap coinciding with irq_clr is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else if (w_wrap_tick) begin
      r_irq <= 1'b1;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

  assign busy    = (r_state != StIdle);
  assign pwm_out = busy && (r_cnt < r_duty_s);
  assign cnt     = r_cnt;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_tick_pwm_gen.sv
// Scoreboard bench for tick_pwm_gen: a per-clock reference model pushes expected outputs,
// a negedge monitor pops and compares. Build with TICK_PWM_IRQ_EN to also cover irq.
module tb_tick_pwm_gen;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset_n;
  logic         tick;
  logic         en;
  logic [W-1:0] period;
  logic [W-1:0] duty;
  logic         irq_clr;
  logic         irq_w;
  logic         pwm_out;
  logic [W-1:0] cnt;
  logic         wrap;
  logic         busy;

  tick_pwm_gen #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .en      (en),
    .period  (period),
    .duty    (duty),
`ifdef TICK_PWM_IRQ_EN
    .irq_clr (irq_clr),
    .irq     (irq_w),
`endif
    .pwm_out (pwm_out),
    .cnt     (cnt),
    .wrap    (wrap),
    .busy    (busy)
  );

`ifndef TICK_PWM_IRQ_EN
  assign irq_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         pwm;
    logic [W-1:0] cnt;
    logic         wrap;
    logic         busy;
    logic         irq;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a period is "active" or not; within it a tick position advances and
  // rolls over after the latched period length. Running vs. draining only matters for en.
  bit m_active;
  int m_pos;
  int m_ps;
  int m_ds;
  bit m_irq;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 0;
      m_pos    = 0;
      m_ps     = 0;
      m_ds     = 0;
      m_irq    = 0;
      q.delete();
    end else begin
      exp_t e;
      bit   end_of_period;
      end_of_period = 0;
      if (!m_active) begin
        if (en) begin
          m_active = 1;
          m_pos    = 0;
          m_ps     = int'(period);
          m_ds     = int'(duty);
        end
      end else if (tick) begin
        if (m_pos == m_ps) begin
          end_of_period = 1;
          m_pos         = 0;
          if (en) begin
            m_ps = int'(period);
            m_ds = int'(duty);
          end else begin
            m_active = 0;
          end
        end else begin
          m_pos = m_pos + 1;
        end
      end
      if (end_of_period) m_irq = 1;
      else if (irq_clr)  m_irq = 0;
      e.busy = m_active;
      e.cnt  = W'(m_pos);
      e.pwm  = m_active && (m_pos < m_ds);
      e.wrap = end_of_period;
      e.irq  = m_irq;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_pwm_out", int'(pwm_out), 0);
      chk("rst_cnt", int'(cnt), 0);
      chk("rst_wrap", int'(wrap), 0);
      chk("rst_busy", int'(busy), 0);
`ifdef TICK_PWM_IRQ_EN
      chk("rst_irq", int'(irq_w), 0);
`endif
    end else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pwm_out", int'(pwm_out), int'(e.pwm));
      chk("cnt", int'(cnt), int'(e.cnt));
      chk("wrap", int'(wrap), int'(e.wrap));
      chk("busy", int'(busy), int'(e.busy));
`ifdef TICK_PWM_IRQ_EN
      chk("irq", int'(irq_w), int'(e.irq));
`endif
    end
  end

  task automatic drive(input logic t, input logic e, input logic [W-1:0] p,
                       input logic [W-1:0] d, input logic c);
    @(posedge clk);
    #1;
    tick    = t;
    en      = e;
    period  = p;
    duty    = d;
    irq_clr = c;
  endtask

  initial begin
    reset_n = 1'b0;
    tick    = 1'b0;
    en      = 1'b0;
    period  = '0;
    duty    = '0;
    irq_clr = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Tick every third clock, period 3, duty 2.
    for (int i = 0; i < 60; i++) drive(i % 3 == 0, 1'b1, 8'd3, 8'd2, 1'b0);
    // Duty edge cases: zero, greater than period, and single-tick periods.
    for (int i = 0; i < 30; i++) drive(i % 2 == 0, 1'b1, 8'd3, 8'd0, 1'b0);
    for (int i = 0; i < 30; i++) drive(i % 2 == 0, 1'b1, 8'd3, 8'd5, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'($urandom_range(0, 1)), 1'b1, 8'd0, 8'd1, 1'b0);
    // Mid-period writes to duty and period.
    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 1)), 1'b1, (i < 10) ? 8'd3 : W'($urandom_range(0, 4)),
            (i < 5) ? 8'd2 : W'($urandom_range(0, 5)), 1'b0);
    // en toggling: stop/restart before and at wrap.
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) > 2), 8'd3, 8'd2,
            ($urandom_range(0, 3) == 0));
    // Asynchronous reset in the middle of a running period.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 8'd4, 8'd4, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_pwm_out", int'(pwm_out), 0);
    chk("async_cnt", int'(cnt), 0);
    chk("async_wrap", int'(wrap), 0);
    chk("async_busy", int'(busy), 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    // Long randomized run with small periods so wraps are frequent.
    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(0, 2) != 0), ($urandom_range(0, 19) != 0),
            W'($urandom_range(0, 6)), W'($urandom_range(0, 8)),
            ($urandom_range(0, 4) == 0));
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'd2, 8'd1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
